// File: rtl/asp_retx_engine.sv
`default_nettype none
// ============================================================================
// Module   : asp_retx_engine
// Purpose  : ASP transmit path. Accepts parity-protected words from the host,
//            discards words whose parity is wrong, and appends an XOR-fold keyed
//            tag. Tagged words are buffered in a small FIFO and sent to the
//            network in order, stop-and-wait. A word is resent when its ACK
//            times out, and it is dropped after MAX_RETRY resends.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                     in   clock, rising edge
//   reset                   in   asynchronous, active-low; clears all state
//   host_valid_in           in   host word valid
//   host_ready_out          out  FIFO can accept (count < DEPTH)
//   data_parity_in          in   [DATA_SIZE:1] data, [0] even-parity bit
//   network_ACK_in          in   ACK for the word in flight
//   network_data_ready_out  out  one-cycle strobe per (re)send
//   network_data_tag_out    out  {data, tag} of FIFO head, 0 when empty
//   parity_error_out        out  one-cycle pulse after a bad-parity accept
//   drop_out                out  one-cycle pulse when the head is abandoned
//   occupancy_out           out  FIFO entry count
// ============================================================================
module asp_retx_engine #(
  parameter int                  DATA_SIZE = 32,
  parameter int                  TAG_SIZE  = 8,
  parameter int                  DEPTH     = 4,
  parameter int                  TIMEOUT   = 64,
  parameter int                  MAX_RETRY = 3,
  parameter logic [TAG_SIZE-1:0] KEY       = 8'hA5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          host_valid_in,
  output logic                          host_ready_out,
  input  logic [DATA_SIZE:0]            data_parity_in,
  input  logic                          network_ACK_in,
  output logic                          network_data_ready_out,
  output logic [DATA_SIZE+TAG_SIZE-1:0] network_data_tag_out,
  output logic                          parity_error_out,
  output logic                          drop_out,
  output logic [$clog2(DEPTH):0]        occupancy_out
);

  // --------------------------------------------------------------------------
  // Derived sizes and constants
  // --------------------------------------------------------------------------
  localparam int c_SLICES = DATA_SIZE / TAG_SIZE;
  localparam int c_PW     = $clog2(DEPTH);
  localparam int c_CW     = c_PW + 1;
  localparam int c_TW     = $clog2(TIMEOUT);
  // One spare bit so the counter can hold MAX_RETRY even when it is 0.
  localparam int c_RW     = $clog2(MAX_RETRY + 2);
  localparam int c_EW     = DATA_SIZE + TAG_SIZE;

  localparam logic [c_CW-1:0] c_DEPTH      = c_CW'(DEPTH);
  localparam logic [c_TW-1:0] c_TIMER_LAST = c_TW'(TIMEOUT - 1);
  localparam logic [c_RW-1:0] c_RETRY_MAX  = c_RW'(MAX_RETRY);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [DATA_SIZE-1:0] w_data;
  logic                 w_par_bit;
  logic                 w_par_bad;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_send;
  logic                 w_drop;
  logic [TAG_SIZE-1:0]  w_tag;

  logic [c_EW-1:0]      r_mem [DEPTH];
  logic [c_PW-1:0]      r_wr_ptr;
  logic [c_PW-1:0]      r_rd_ptr;
  logic [c_CW-1:0]      r_count;
  logic                 r_perr;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_TW-1:0]      r_timer;
  logic [c_TW-1:0]      w_timer_nxt;
  logic [c_RW-1:0]      r_retry;
  logic [c_RW-1:0]      w_retry_nxt;

  // --------------------------------------------------------------------------
  // Host side: parity check and tag generation
  // --------------------------------------------------------------------------
  assign w_data    = data_parity_in[DATA_SIZE:1];
  assign w_par_bit = data_parity_in[0];
  assign w_par_bad = (^w_data) != w_par_bit;

  assign host_ready_out = (r_count < c_DEPTH);
  assign w_accept       = host_valid_in && host_ready_out;
  // Bad-parity words complete the handshake but are never stored.
  assign w_push         = w_accept && !w_par_bad;

  // XOR-fold of all TAG_SIZE slices of the payload, keyed.
  always_comb begin
    w_tag = KEY;
    for (int i = 0; i < c_SLICES; i++) begin
      w_tag = w_tag ^ w_data[i*TAG_SIZE +: TAG_SIZE];
    end
  end

  // --------------------------------------------------------------------------
  // Retransmit FIFO
  // --------------------------------------------------------------------------
  // Storage needs no reset: the head is masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_data, w_tag};
    end
  end

  // Pointers are exactly c_PW bits wide, so +1 wraps modulo DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_perr   <= 1'b0;
    end else begin
      r_perr <= w_accept && w_par_bad;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Stop-and-wait FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_retry <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_retry <= w_retry_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Stop-and-wait FSM: next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_retry_nxt = r_retry;
    w_pop       = 1'b0;
    w_send      = 1'b0;
    w_drop      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (r_count != '0) begin
          w_state_nxt = ST_SEND;
        end
      end

      ST_SEND: begin
        w_send      = 1'b1;
        w_timer_nxt = '0;
        w_state_nxt = ST_WAIT;
      end

      ST_WAIT: begin
        // ACK takes priority over a timeout landing in the same cycle.
        if (network_ACK_in) begin
          w_pop       = 1'b1;
          w_retry_nxt = '0;
          w_state_nxt = ST_IDLE;
        end else if (r_timer == c_TIMER_LAST) begin
          if (r_retry < c_RETRY_MAX) begin
            w_retry_nxt = r_retry + 1'b1;
            w_state_nxt = ST_SEND;
          end else begin
            // Retries exhausted: abandon the head so the queue keeps moving.
            w_pop       = 1'b1;
            w_drop      = 1'b1;
            w_retry_nxt = '0;
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign network_data_ready_out = w_send;
  assign drop_out               = w_drop;
  assign parity_error_out       = r_perr;
  assign occupancy_out          = r_count;
  assign network_data_tag_out   = (r_count == '0) ? '0 : r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: tb/tb_asp_retx_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_asp_retx_engine
// Purpose  : Self-checking bench for asp_retx_engine. A queue-based reference
//            model derives every expected output from the send schedule of the
//            current head word: first send two cycles after it became
//            eligible, resends every TIMEOUT+1 cycles, drop at the end of the
//            last wait window. Table vectors, directed timing sequences and
//            random traffic all run through the same per-cycle checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_asp_retx_engine;

  localparam int DW        = 32;
  localparam int TW        = 8;
  localparam int DEPTH     = 4;
  localparam int TIMEOUT   = 64;
  localparam int MAX_RETRY = 3;
  localparam logic [TW-1:0] KEY = 8'hA5;
  localparam int P         = TIMEOUT + 1;
  localparam int LAST      = MAX_RETRY * P + TIMEOUT;

  logic              clk = 1'b0;
  logic              reset;
  logic              host_valid_in;
  logic              host_ready_out;
  logic [DW:0]       data_parity_in;
  logic              network_ACK_in;
  logic              network_data_ready_out;
  logic [DW+TW-1:0]  network_data_tag_out;
  logic              parity_error_out;
  logic              drop_out;
  logic [2:0]        occupancy_out;

  asp_retx_engine #(
    .DATA_SIZE (DW),
    .TAG_SIZE  (TW),
    .DEPTH     (DEPTH),
    .TIMEOUT   (TIMEOUT),
    .MAX_RETRY (MAX_RETRY),
    .KEY       (KEY)
  ) u_dut (
    .clk                    (clk),
    .reset                  (reset),
    .host_valid_in          (host_valid_in),
    .host_ready_out         (host_ready_out),
    .data_parity_in         (data_parity_in),
    .network_ACK_in         (network_ACK_in),
    .network_data_ready_out (network_data_ready_out),
    .network_data_tag_out   (network_data_tag_out),
    .parity_error_out       (parity_error_out),
    .drop_out               (drop_out),
    .occupancy_out          (occupancy_out)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Bookkeeping and reference model state
  // --------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [DW-1:0] d;
    int            pc;   // cycle at whose closing edge the word was stored
  } ent_t;

  ent_t q[$];
  int   last_pop;        // cycle at whose closing edge the last pop happened
  logic m_perr;

  logic             obs_rdy, obs_drop, obs_perr, obs_hrdy;
  logic [DW+TW-1:0] obs_tag;
  logic [2:0]       obs_occ;

  typedef struct {
    logic [DW-1:0]    d;
    logic             p;
    logic             err;
    logic [DW+TW-1:0] out;
  } vec_t;

  vec_t vec [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %0h, wanted %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [TW-1:0] ref_tag(input logic [DW-1:0] d);
    logic [TW-1:0] t;
    t = KEY;
    for (int i = 0; i < DW / TW; i++) t ^= d[i*TW +: TW];
    return t;
  endfunction

  function automatic logic [DW:0] mkword(input logic [DW-1:0] d, input bit good);
    return {d, good ? (^d) : ~(^d)};
  endfunction

  // One clock cycle: drive inputs, compare all outputs with the model,
  // advance the model across the closing edge. Entered and left at negedge.
  task automatic cycle(input logic v, input logic [DW:0] dp, input logic ack);
    int  e;
    bit  ne, exp_rdy, in_wait, ack_eff, exp_drop, acc, bad;
    logic [DW+TW-1:0] exp_tag;
    host_valid_in  = v;
    data_parity_in = dp;
    network_ACK_in = ack;
    #1;
    ne = q.size() > 0;
    e  = -1;
    if (ne) e = cyc - ((last_pop > q[0].pc) ? last_pop : q[0].pc) - 2;
    exp_rdy  = ne && (e >= 0) && (e % P == 0) && (e / P <= MAX_RETRY);
    in_wait  = ne && (e >= 1) && (e <= LAST) && (e % P != 0);
    ack_eff  = ack && in_wait;
    exp_drop = ne && (e == LAST) && !ack;
    exp_tag  = ne ? {q[0].d, ref_tag(q[0].d)} : '0;

    obs_rdy  = network_data_ready_out;
    obs_drop = drop_out;
    obs_perr = parity_error_out;
    obs_hrdy = host_ready_out;
    obs_tag  = network_data_tag_out;
    obs_occ  = occupancy_out;

    check("ready_out",  obs_rdy,  exp_rdy);
    check("drop_out",   obs_drop, exp_drop);
    check("parity_err", obs_perr, m_perr);
    check("host_ready", obs_hrdy, q.size() < DEPTH);
    check("tag_out",    obs_tag,  exp_tag);
    check("occupancy",  obs_occ,  q.size());

    acc = v && (q.size() < DEPTH);
    bad = (^dp[DW:1]) != dp[0];
    if (ack_eff || exp_drop) begin
      void'(q.pop_front());
      last_pop = cyc;
    end
    if (acc && !bad) q.push_back('{d: dp[DW:1], pc: cyc});
    m_perr = acc && bad;

    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, releases it a
  // cycle later. Entered and left at negedge.
  task automatic apply_reset();
    reset          = 1'b0;
    host_valid_in  = 1'b0;
    network_ACK_in = 1'b0;
    data_parity_in = '0;
    #1;
    check("rst_ready_out",  network_data_ready_out, 0);
    check("rst_drop",       drop_out, 0);
    check("rst_parity_err", parity_error_out, 0);
    check("rst_tag_out",    network_data_tag_out, 0);
    check("rst_occupancy",  occupancy_out, 0);
    check("rst_host_ready", host_ready_out, 1);
    q.delete();
    last_pop = -1000;
    m_perr   = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sends[$];
    int drops[$];
    int idx;
    int nsend;
    logic v;
    logic [DW-1:0] wd [5];

    reset          = 1'b0;
    host_valid_in  = 1'b0;
    network_ACK_in = 1'b0;
    data_parity_in = '0;
    last_pop       = -1000;
    m_perr         = 1'b0;

    vec[0] = '{32'h12345678, 1'b1, 1'b0, 40'h12345678AD};
    vec[1] = '{32'h12345678, 1'b0, 1'b1, 40'h0};
    vec[2] = '{32'h00000000, 1'b0, 1'b0, 40'h00000000A5};
    vec[3] = '{32'h00000000, 1'b1, 1'b1, 40'h0};
    vec[4] = '{32'hFFFFFFFF, 1'b0, 1'b0, 40'hFFFFFFFFA5};
    vec[5] = '{32'h000000FF, 1'b0, 1'b0, 40'h000000FF5A};
    vec[6] = '{32'h01000000, 1'b1, 1'b0, 40'h01000000A4};
    vec[7] = '{32'hA5000000, 1'b0, 1'b0, 40'hA500000000};
    vec[8] = '{32'h80000001, 1'b0, 1'b0, 40'h8000000124};

    @(negedge clk);

    // ---- Table: single word, tag/parity, send in cycle 2, ACK in cycle 3 ----
    for (int i = 0; i < 9; i++) begin
      apply_reset();
      cycle(1'b1, {vec[i].d, vec[i].p}, 1'b0);
      cycle(1'b0, '0, 1'b0);
      check("vec_parity_err", obs_perr, vec[i].err);
      check("vec_occ_t1", obs_occ, vec[i].err ? 0 : 1);
      cycle(1'b0, '0, 1'b0);
      check("vec_send_t2", obs_rdy, !vec[i].err);
      check("vec_tag_t2", obs_tag, vec[i].out);
      cycle(1'b0, '0, 1'b1);
      cycle(1'b0, '0, 1'b0);
      check("vec_occ_after_ack", obs_occ, 0);
    end

    // ---- Word 0x12345678: send in cycle 2, ACK in cycle 5 ----
    apply_reset();
    for (int t = 0; t <= 6; t++) begin
      cycle(t == 0, mkword(32'h12345678, 1'b1), t == 5);
      if (t == 2) begin
        check("t1_send_c2", obs_rdy, 1);
        check("t1_tag_c2", obs_tag, 40'h12345678AD);
      end
      if (t == 6) check("t1_occ_after_ack", obs_occ, 0);
    end

    // ---- No ACK: sends at 2, 67, 132, 197; drop at 261 ----
    apply_reset();
    sends.delete();
    drops.delete();
    for (int t = 0; t <= 275; t++) begin
      cycle(t == 0, mkword(32'hCAFEF00D, 1'b1), 1'b0);
      if (obs_rdy)  sends.push_back(t);
      if (obs_drop) drops.push_back(t);
    end
    check("t3_send_count", sends.size(), 4);
    for (int k = 0; k < 4 && k < sends.size(); k++)
      check("t3_send_cycle", sends[k], 2 + k * P);
    check("t3_drop_count", drops.size(), 1);
    if (drops.size() > 0) check("t3_drop_cycle", drops[0], 261);
    check("t3_occ_end", obs_occ, 0);

    // ---- Five pushes, FIFO full after four, ACK releases the fifth ----
    for (int i = 0; i < 5; i++) wd[i] = 32'h11111111 * (i + 1);
    apply_reset();
    idx = 0;
    for (int t = 0; t < 12; t++) begin
      v = (idx < 5);
      cycle(v, mkword(wd[(idx < 5) ? idx : 0], 1'b1), t == 5);
      if (v && obs_hrdy) idx++;
      if (t == 4) check("t4_ready_low_full", obs_hrdy, 0);
      if (t == 6) check("t4_ready_after_ack", obs_hrdy, 1);
      if (t == 7) begin
        check("t4_second_sent", obs_rdy, 1);
        check("t4_second_tag", obs_tag, {wd[1], ref_tag(wd[1])});
      end
    end
    for (int t = 0; t < 40; t++) cycle(1'b0, '0, 1'b1);
    check("t4_drained", obs_occ, 0);

    // ---- ACK coinciding with the timeout after one resend ----
    apply_reset();
    sends.delete();
    drops.delete();
    for (int t = 0; t <= 400; t++) begin
      cycle(t <= 1, mkword((t == 0) ? 32'h0BADBEEF : 32'h600DCAFE, 1'b1), t == 131);
      if (t == 131) check("t5_no_drop_on_ack", obs_drop, 0);
      if (t == 132) begin
        check("t5_popped", obs_occ, 1);
        check("t5_no_resend", obs_rdy, 0);
      end
      if (t >= 132 && obs_rdy)  sends.push_back(t);
      if (t >= 132 && obs_drop) drops.push_back(t);
    end
    check("t5_next_full_retries", sends.size(), 4);
    if (sends.size() > 0) check("t5_next_first_send", sends[0], 133);
    check("t5_next_drop_count", drops.size(), 1);
    if (drops.size() > 0) check("t5_next_drop_cycle", drops[0], 392);

    // ---- Reset during WAIT_ACK with words queued ----
    apply_reset();
    for (int t = 0; t <= 10; t++)
      cycle(t <= 2, mkword(32'h0000_0100 + t, 1'b1), 1'b0);
    check("t6_queued", obs_occ, 3);
    apply_reset();
    nsend = 0;
    for (int t = 0; t < 150; t++) begin
      cycle(1'b0, '0, 1'b0);
      if (obs_rdy) nsend++;
    end
    check("t6_no_stale_send", nsend, 0);

    // ---- Random traffic against the model ----
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) apply_reset();
      cycle($urandom_range(0, 99) < 35,
            mkword($urandom, $urandom_range(0, 99) >= 15),
            (i < 1500) ? ($urandom_range(0, 99) < 6) : ($urandom_range(0, 999) < 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
